// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared state encoding, port indices and word geometry
// for data_mem_arbiter and its winner-select sub-block.
package data_mem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} stateT;
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;
   localparam int WORD_BYTES = 3;
endpackage

// File: rtl/data_mem_arb_select.sv
// arb2_select: two-port winner selection. With ARB_ROUND_ROBIN_EN defined a
// contention goes to the port that did not win last; otherwise port 0 always wins.
module arb2_select
   import data_mem_arb_pkg::*;
(
   input  logic Req0,
   input  logic Req1,
   input  logic LastGrant,
   output logic GrantIdx,
   output logic Valid
);
   assign Valid = Req0 | Req1;
`ifdef ARB_ROUND_ROBIN_EN
   assign GrantIdx = (Req0 & Req1) ? ~LastGrant : (Req0 ? PORT_CPU : PORT_DBG);
`else
   logic unusedLastGrant;
   assign unusedLastGrant = LastGrant;
   assign GrantIdx = Req0 ? PORT_CPU : PORT_DBG;
`endif
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data memory between CPU (port 0) and debug/DMA (port 1),
// one access per IDLE->ACCESS->DONE pass. Define ARB_ROUND_ROBIN_EN for round-robin contention.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int MEM_BYTES  = 128,
   parameter int WORD_BYTES = data_mem_arb_pkg::WORD_BYTES
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        Write0,
   input  logic        Write1,
   input  logic [23:0] Addr0,
   input  logic [23:0] Addr1,
   input  logic [23:0] WData0,
   input  logic [23:0] WData1,
   output logic        Ack0,
   output logic        Ack1,
   output logic        Err0,
   output logic        Err1,
   output logic [23:0] RData0,
   output logic [23:0] RData1,
   output logic [23:0] MemAddress,
   output logic [23:0] MemWriteData,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [23:0] MemReadData
);
   localparam logic [23:0] MAX_ADDR = 24'(MEM_BYTES - WORD_BYTES);
   stateT state, stateNext;
   logic grantIdx, grantValid, grantNow, lastGrant;
   logic curIdx, curWrite, curErr;
   logic [23:0] curAddr, curWData, selAddr;

   arb2_select uSelect (
      .Req0(Req0),
      .Req1(Req1),
      .LastGrant(lastGrant),
      .GrantIdx(grantIdx),
      .Valid(grantValid)
   );

   assign grantNow = (state == IDLE) && grantValid;
   assign selAddr  = grantIdx ? Addr1 : Addr0;

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) lastGrant <= PORT_DBG;
      else if (grantNow) lastGrant <= grantIdx;
   end
`else
   assign lastGrant = PORT_DBG;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else state <= stateNext;
   end

   always_comb begin
      stateNext    = grantNow ? ACCESS : (state == ACCESS) ? DONE : IDLE;
      MemAddress   = (state == ACCESS) ? curAddr : '0;
      MemWriteData = (state == ACCESS) ? curWData : '0;
      MemWrite     = (state == ACCESS) & curWrite & ~curErr;
      MemRead      = (state == ACCESS) & ~curWrite & ~curErr;
      Ack0         = (state == DONE) & (curIdx == PORT_CPU);
      Ack1         = (state == DONE) & (curIdx == PORT_DBG);
      Err0         = Ack0 & curErr;
      Err1         = Ack1 & curErr;
   end

   // Range is judged once at grant, so strobe suppression and Err always agree.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         curIdx   <= PORT_CPU;
         curWrite <= 1'b0;
         curErr   <= 1'b0;
         curAddr  <= '0;
         curWData <= '0;
         RData0   <= '0;
         RData1   <= '0;
      end else begin
         if (grantNow) begin
            curIdx   <= grantIdx;
            curWrite <= grantIdx ? Write1 : Write0;
            curAddr  <= selAddr;
            curWData <= grantIdx ? WData1 : WData0;
            curErr   <= selAddr > MAX_ADDR;
         end
         if (state == ACCESS && !curWrite && curIdx == PORT_CPU) RData0 <= curErr ? '0 : MemReadData;
         if (state == ACCESS && !curWrite && curIdx == PORT_DBG) RData1 <= curErr ? '0 : MemReadData;
      end
   end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning data memory size in bytes.
REQ-002 SHALL have parameter WORD_BYTES, default 3, meaning bytes per 24-bit big-endian word.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port Clock  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Req0 / Req1  input  1 each  access request, port 0 = CPU, port 1 = debug/DMA.
REQ-007 SHALL have port Write0 / Write1  input  1 each  1 = store, 0 = load.
REQ-008 SHALL have port Addr0 / Addr1  input  24 each  byte address of the word's MSB byte.
REQ-009 SHALL have port WData0 / WData1  input  24 each  store data.
REQ-010 SHALL have port Ack0 / Ack1  output  1 each  one-cycle completion pulse.
REQ-011 SHALL have port Err0 / Err1  output  1 each  out-of-range flag, valid with Ack.
REQ-012 SHALL have port RData0 / RData1  output  24 each  load data, valid with Ack.
REQ-013 SHALL have port MemAddress  output  24  to DataMemory Address.
REQ-014 SHALL have port MemWriteData  output  24  to DataMemory WriteData.
REQ-015 SHALL have ports MemWrite / MemRead  output  1 each  DataMemory strobes.
REQ-016 SHALL have port MemReadData  input  24  from DataMemory ReadData.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-018 IDLE: with any Req high, SHALL select a winner per REQ-024/REQ-030, register its Write/Addr/WData/index, and enter ACCESS on that edge; with no Req, SHALL stay in IDLE.
REQ-019 ACCESS (exactly 1 cycle): SHALL drive MemAddress/MemWriteData from registers; MemWrite = Write & ~Err; MemRead = ~Write & ~Err; on the closing edge, SHALL capture MemReadData for loads.
REQ-020 DONE: SHALL pulse only the winner's Ack for 1 cycle with RData/Err valid, then return to IDLE.
REQ-021 Latency SHALL be Req sampled at edge N, Ack high in cycle N+2; throughput SHALL be one access per 3 cycles.
REQ-022 Outside ACCESS, SHALL hold MemWrite = MemRead = 0 and MemAddress = 0.
REQ-023 Requester SHALL hold Req until Ack; a Req still high in the cycle after Ack SHALL be arbitrated as a new request; a Req dropped after grant SHALL still complete, with Ack issued.
REQ-024 Range: Err SHALL be 1 when Addr > MEM_BYTES - WORD_BYTES (24-bit unsigned compare, no wrap); on Err, SHALL issue no strobe and return RData = 0; Ack still SHALL pulse.
REQ-025 RData of the non-winning port SHALL hold its last value; store Ack SHALL leave RData unchanged.
REQ-026 Simultaneous Req0 and Req1: the loser SHALL wait, with no Ack, and SHALL be served in the next IDLE.

Reset
REQ-027 Reset asserted SHALL immediately force state IDLE, with all Ack/Err/MemWrite/MemRead = 0, all RData = 0, MemAddress = MemWriteData = 0, and LastGrant = 1.
REQ-028 Reset during ACCESS SHALL abort the access: the strobe drops asynchronously, no Ack issues, and the requester SHALL re-request.
REQ-029 After Reset deasserts, the first arbitration SHALL occur at the first rising edge.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, a contention winner SHALL be the port not equal to LastGrant, with LastGrant updated on every grant; without it, port 0 SHALL always win and LastGrant SHALL be unused/removed.

Structure
REQ-031 Package data_mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), the port indices PORT_CPU=0 / PORT_DBG=1, and WORD_BYTES.
REQ-032 The winner selection plus LastGrant SHALL be a sub-module arb2_select (inputs Req0, Req1, LastGrant; output GrantIdx, Valid); the FSM and datapath SHALL stay in data_mem_arbiter.

Verification
REQ-033 Store via port 0: Addr0=0x000010, WData0=0xABCDEF -> MemWrite high for 1 cycle, Ack0 at N+2; then a load of 0x000010 via port 1 -> RData1=0xABCDEF.
REQ-034 Both Req high from IDLE -> with the macro: port 0, then port 1, then port 0 alternating; without the macro: port 0 continuously while Req0 stays high.
REQ-035 Addr0=0x00007D (125) -> valid; Addr0=0x00007E (126) and 0xFFFFFF -> Err0=1, Ack0=1, RData0=0, no MemWrite/MemRead.
REQ-036 Reset asserted mid-ACCESS of a store -> MemWrite falls the same cycle, no Ack, state IDLE; the memory word is unchanged.
REQ-037 Req1 dropped one cycle after grant -> Ack1 still pulses at N+2; no second access occurs.
